// File: rtl/dual_port_dmem.sv
// Two-port 16-bit data memory for the dual-issue core.
// Self-clearing after reset, p1-priority writes, write-first cross-port reads.
module dual_port_dmem #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] p0_maddr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic              p0_write_mem,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic [ADDR_W-1:0] p1_maddr,
   input  logic [DATA_W-1:0] p1_wdata,
   input  logic              p1_write_mem,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              clr_busy
);

   localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (IDX_W > 1) ? IDX_W - 1 : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH / 2 - 1);

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t state;
   logic [CNT_W-1:0] clr_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic p0_ok;
   logic p1_ok;
   logic w0;
   logic w1;
   logic same;
   logic [IDX_W-1:0] idx0;
   logic [IDX_W-1:0] idx1;
   logic [IDX_W-1:0] clr_lo;
   logic [IDX_W-1:0] clr_hi;
   logic [DATA_W-1:0] rd0;
   logic [DATA_W-1:0] rd1;

   // One extra address bit lets DEPTH == 2**ADDR_W compare cleanly.
   assign p0_ok = ({1'b0, p0_maddr} < DEPTH_X);
   assign p1_ok = ({1'b0, p1_maddr} < DEPTH_X);
   assign w0 = p0_write_mem & p0_ok;
   assign w1 = p1_write_mem & p1_ok;
   assign same = (p0_maddr == p1_maddr);
   assign idx0 = p0_maddr[IDX_W-1:0];
   assign idx1 = p1_maddr[IDX_W-1:0];
   assign clr_lo = IDX_W'({clr_cnt, 1'b0});
   assign clr_hi = clr_lo | IDX_W'(1);

   always_comb begin
      rd0 = '0;
      if (p0_ok) begin
         if (w1 && same) begin
            rd0 = p1_wdata;
         end else if (w0) begin
            rd0 = p0_wdata;
         end else begin
            rd0 = mem[idx0];
         end
      end
   end

   always_comb begin
      rd1 = '0;
      if (p1_ok) begin
         if (w1) begin
            rd1 = p1_wdata;
         end else if (w0 && same) begin
            rd1 = p0_wdata;
         end else begin
            rd1 = mem[idx1];
         end
      end
   end

   // p1 is the younger instruction, so it owns a shared address.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_lo] <= '0;
         mem[clr_hi] <= '0;
      end else if (rst) begin
         if (w0 && !(w1 && same)) begin
            mem[idx0] <= p0_wdata;
         end
         if (w1) begin
            mem[idx1] <= p1_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= CLEAR;
         clr_cnt  <= '0;
         clr_busy <= 1'b1;
         p0_rdata <= '0;
         p1_rdata <= '0;
      end else begin
         unique case (state)
            CLEAR: begin
               p0_rdata <= '0;
               p1_rdata <= '0;
               clr_cnt  <= clr_cnt + 1'b1;
               if (clr_cnt == CNT_LAST) begin
                  state    <= READY;
                  clr_busy <= 1'b0;
               end
            end
            READY: begin
               p0_rdata <= rd0;
               p1_rdata <= rd1;
            end
            default: begin
               state <= CLEAR;
            end
         endcase
      end
   end

endmodule
